// File: rtl/m2_pkg.sv
// rtl/m2_pkg.sv - shared writer state type, default geometry, zigzag LUT and Q-matrix shift helpers
package m2_pkg;

    typedef enum logic [1:0] {
        S_PW_IDLE,
        S_PW_WAIT,
        S_PW_WRITE,
        S_PW_DONE
    } preidct_writer_state_type;

    localparam logic [17:0] PREIDCT_BASE_DEF = 18'd76800;
    localparam int          Y_WIDTH_DEF      = 320;
    localparam int          IMG_HEIGHT_DEF   = 240;

    localparam logic [5:0] ZZ_TAB [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    function automatic logic [5:0] zz2nat(input logic [5:0] zz);
        return ZZ_TAB[zz];
    endfunction

    // rc is natural row + col of the coefficient (0..14)
    function automatic logic [2:0] q_shift(input logic q_sel, input logic [3:0] rc);
        if (rc == 4'd0) return 3'd3;
        if (!q_sel) begin
            if (rc == 4'd1) return 3'd2;
            if (rc <= 4'd3) return 3'd3;
            if (rc <= 4'd5) return 3'd4;
            if (rc <= 4'd7) return 3'd5;
            return 3'd6;
        end
        if (rc <= 4'd3) return 3'd1;
        if (rc <= 4'd5) return 3'd2;
        if (rc <= 4'd7) return 3'd3;
        return 3'd4;
    endfunction

endpackage

// File: rtl/preidct_pingpong_buf.sv
// rtl/preidct_pingpong_buf.sv - two 64x16 coefficient banks with fill/drain selects and full flags
module preidct_pingpong_buf (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        wr_en_i,
    input  logic [5:0]  wr_idx_i,
    input  logic [15:0] wr_data_i,
    input  logic        fill_done_i,
    input  logic        drain_done_i,
    input  logic [5:0]  rd_idx_i,
    output logic [15:0] rd_data_o,
    output logic        fill_full_o,
    output logic        drain_full_o
);

    logic [15:0] bank_q [2][64];
    logic [1:0]  full_q, full_d;
    logic        fsel_q, dsel_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) bank_q[fsel_q][wr_idx_i] <= wr_data_i;
    end

    // fill and drain always target different banks, so both updates can land together
    always_comb begin
        full_d = full_q;
        if (fill_done_i)  full_d[fsel_q] = 1'b1;
        if (drain_done_i) full_d[dsel_q] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            full_q <= '0;
            fsel_q <= 1'b0;
            dsel_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (fill_done_i)  fsel_q <= ~fsel_q;
            if (drain_done_i) dsel_q <= ~dsel_q;
        end
    end

    assign rd_data_o    = bank_q[dsel_q][rd_idx_i];
    assign fill_full_o  = full_q[fsel_q];
    assign drain_full_o = full_q[dsel_q];

endmodule

// File: rtl/preidct_block_writer.sv
// rtl/preidct_block_writer.sv - dequantizes zigzag coefficients, de-zigzags into a ping-pong buffer
// and writes each 8x8 block to SRAM in block-raster order over the Y, U and V planes
module preidct_block_writer
    import m2_pkg::*;
#(
    parameter logic [17:0] PREIDCT_BASE = PREIDCT_BASE_DEF,
    parameter int          Y_WIDTH      = Y_WIDTH_DEF,
    parameter int          IMG_HEIGHT   = IMG_HEIGHT_DEF
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    input  logic        q_sel,
    input  logic        coeff_valid,
    input  logic [15:0] coeff_data,
    output logic        coeff_ready,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    output logic        Done
);

    localparam logic [17:0] Y_STRIDE  = 18'(Y_WIDTH);
    localparam logic [17:0] UV_STRIDE = 18'(Y_WIDTH / 2);
    localparam logic [5:0]  Y_COL_LAST  = 6'(Y_WIDTH / 8 - 1);
    localparam logic [5:0]  UV_COL_LAST = 6'(Y_WIDTH / 16 - 1);
    localparam logic [4:0]  BROW_LAST   = 5'(IMG_HEIGHT / 8 - 1);
    localparam logic [17:0] U_BASE = PREIDCT_BASE + 18'(Y_WIDTH * IMG_HEIGHT);
    localparam logic [17:0] V_BASE = U_BASE + 18'((Y_WIDTH / 2) * IMG_HEIGHT);

    preidct_writer_state_type state_q, state_d;
    logic        q_sel_q, q_sel_d;
    logic [5:0]  zz_q, zz_d;
    logic [5:0]  n_q, n_d;
    logic [5:0]  blk_col_q, blk_col_d;
    logic [4:0]  blk_row_q, blk_row_d;
    logic [1:0]  plane_q, plane_d;
    logic [17:0] row_base_q, row_base_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        we_n_q, we_n_d;
    logic        done_q, done_d;

    logic        hs, fill_done, drain_done, fill_full, drain_full;
    logic [5:0]  nat;
    logic [3:0]  rc;
    logic signed [23:0] deq_wide;
    logic [15:0] deq_sat, rd_data;
    logic [17:0] stride, elem_addr;
    logic [5:0]  last_col;

    assign coeff_ready = (state_q == S_PW_WAIT || state_q == S_PW_WRITE) && !fill_full;
    assign hs          = coeff_valid && coeff_ready;
    assign fill_done   = hs && (zz_q == 6'd63);

    always_comb begin
        nat      = zz2nat(zz_q);
        rc       = {1'b0, nat[5:3]} + {1'b0, nat[2:0]};
        deq_wide = {{8{coeff_data[15]}}, coeff_data} <<< q_shift(q_sel_q, rc);
        if (deq_wide > 24'sd32767)       deq_sat = 16'h7fff;
        else if (deq_wide < -24'sd32768) deq_sat = 16'h8000;
        else                             deq_sat = deq_wide[15:0];
    end

    always_comb begin
        zz_d = zz_q;
        if (state_q == S_PW_IDLE && Enable) zz_d = '0;
        else if (hs)                        zz_d = zz_q + 6'd1;
    end

    preidct_pingpong_buf u_buf (
        .clk_i        (Clock),
        .resetn_i     (Resetn),
        .wr_en_i      (hs),
        .wr_idx_i     (nat),
        .wr_data_i    (deq_sat),
        .fill_done_i  (fill_done),
        .drain_done_i (drain_done),
        .rd_idx_i     (n_q),
        .rd_data_o    (rd_data),
        .fill_full_o  (fill_full),
        .drain_full_o (drain_full)
    );

    // n_q is 0 while waiting, so element 0 is addressed on the WAIT->WRITE transition
    assign stride    = (plane_q == 2'd0) ? Y_STRIDE : UV_STRIDE;
    assign last_col  = (plane_q == 2'd0) ? Y_COL_LAST : UV_COL_LAST;
    assign elem_addr = row_base_q + {9'd0, blk_col_q, 3'd0}
                     + 18'(n_q[5:3]) * stride + {15'd0, n_q[2:0]};

    always_comb begin
        state_d    = state_q;
        q_sel_d    = q_sel_q;
        n_d        = n_q;
        blk_col_d  = blk_col_q;
        blk_row_d  = blk_row_q;
        plane_d    = plane_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we_n_d     = 1'b1;
        done_d     = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            S_PW_IDLE: if (Enable) begin
                state_d    = S_PW_WAIT;
                q_sel_d    = q_sel;
                n_d        = '0;
                blk_col_d  = '0;
                blk_row_d  = '0;
                plane_d    = '0;
                row_base_d = PREIDCT_BASE;
            end
            S_PW_WAIT: if (drain_full) begin
                state_d = S_PW_WRITE;
                we_n_d  = 1'b0;
                addr_d  = elem_addr;
                data_d  = rd_data;
                n_d     = 6'd1;
            end
            S_PW_WRITE: if (n_q != 6'd0) begin
                we_n_d = 1'b0;
                addr_d = elem_addr;
                data_d = rd_data;
                n_d    = n_q + 6'd1;
            end else begin
                drain_done = 1'b1;
                state_d    = S_PW_WAIT;
                if (blk_col_q == last_col) begin
                    blk_col_d  = '0;
                    blk_row_d  = blk_row_q + 5'd1;
                    row_base_d = row_base_q + (stride << 3);
                    if (blk_row_q == BROW_LAST) begin
                        blk_row_d  = '0;
                        plane_d    = plane_q + 2'd1;
                        row_base_d = (plane_q == 2'd0) ? U_BASE : V_BASE;
                        if (plane_q == 2'd2) begin
                            state_d = S_PW_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end else begin
                    blk_col_d = blk_col_q + 6'd1;
                end
            end
            S_PW_DONE: state_d = S_PW_IDLE;
            default:   state_d = S_PW_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q    <= S_PW_IDLE;
            q_sel_q    <= 1'b0;
            zz_q       <= '0;
            n_q        <= '0;
            blk_col_q  <= '0;
            blk_row_q  <= '0;
            plane_q    <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_n_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_sel_q    <= q_sel_d;
            zz_q       <= zz_d;
            n_q        <= n_d;
            blk_col_q  <= blk_col_d;
            blk_row_q  <= blk_row_d;
            plane_q    <= plane_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            we_n_q     <= we_n_d;
            done_q     <= done_d;
        end
    end

    assign SRAM_address    = addr_q;
    assign SRAM_write_data = data_q;
    assign SRAM_we_n       = we_n_q;
    assign Done            = done_q;

endmodule
